// File: rtl/md5_search_ctrl.sv
// Feeds padded candidates into the 65-stage MD5 core, compares each retiring digest with a latched target and reports hits.
// Optional MD5_CTRL_STOP_ON_MATCH_EN: stop consuming the stream at the first hit and present only that hit.
module md5_search_ctrl #(
    parameter int PIPE_DEPTH = 65,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [127:0]     cfg_target,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [447:0]     s_data,
    input  logic [15:0]      s_len,
    input  logic             s_last,
    output logic             core_en,
    output logic [447:0]     core_m_in,
    output logic [15:0]      core_length,
    output logic             core_valid_in,
    input  logic [31:0]      core_a,
    input  logic [31:0]      core_b,
    input  logic [31:0]      core_c,
    input  logic [31:0]      core_d,
    input  logic [511:0]     core_m_out,
    input  logic             core_valid_out,
    output logic             match_valid,
    input  logic             match_ready,
    output logic [447:0]     match_msg,
    output logic [15:0]      match_len,
    output logic [CNT_W-1:0] hash_count,
    output logic [CNT_W-1:0] match_count
);
    localparam int INF_W = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [127:0]     target;
    logic [INF_W-1:0] inflight;
    logic             stop_hit;
    logic             accept;
    logic             retire;
    logic             hit;
    logic             present;
    logic             unused_bits;

    // An unconsumed match freezes the whole core so no later digest is lost.
    assign core_en       = !match_valid || match_ready;
    assign s_ready       = (state == RUN) && core_en;
    assign accept        = s_valid && s_ready;
    assign core_valid_in = accept;
    assign core_m_in     = s_data;
    assign core_length   = s_len;

    assign retire = core_en && core_valid_out && (state != IDLE);
    assign hit    = retire && ({core_a, core_b, core_c, core_d} == target);

`ifdef MD5_CTRL_STOP_ON_MATCH_EN
    assign present = hit && !stop_hit;
`else
    assign present = hit;
`endif

    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign unused_bits = ^core_m_out[47:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            target      <= '0;
            inflight    <= '0;
            stop_hit    <= 1'b0;
            match_valid <= 1'b0;
            match_msg   <= '0;
            match_len   <= '0;
            hash_count  <= '0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target      <= cfg_target;
                        hash_count  <= '0;
                        match_count <= '0;
                        stop_hit    <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
`ifdef MD5_CTRL_STOP_ON_MATCH_EN
                    if ((accept && s_last) || hit)
                        state <= DRAIN;
`else
                    if (accept && s_last)
                        state <= DRAIN;
`endif
                end
                DRAIN: begin
                    if (inflight == '0 && !match_valid)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase

            if (retire)
                hash_count <= hash_count + CNT_W'(1);
            if (hit) begin
                match_count <= match_count + CNT_W'(1);
                stop_hit    <= 1'b1;
            end

            // The core stores length little-endian in m_out[63:48].
            if (present) begin
                match_valid <= 1'b1;
                match_msg   <= core_m_out[511:64];
                match_len   <= {core_m_out[55:48], core_m_out[63:56]};
            end else if (match_valid && match_ready) begin
                match_valid <= 1'b0;
            end

            if (accept && !retire)
                inflight <= inflight + INF_W'(1);
            else if (!accept && retire)
                inflight <= inflight - INF_W'(1);
        end
    end
endmodule

// File: tb/tb_md5_search_ctrl.sv
// Directed bench for md5_search_ctrl with a behavioural 65-stage core whose digest is a lookup on the message.
module tb_md5_search_ctrl;
    localparam int PD = 65;
    localparam logic [447:0] ABC_MSG = {32'h61626380, 416'h0};
    localparam logic [127:0] ABC_DIG = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] TGT2    = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] cfg_target;
    logic         busy, done;
    logic         s_valid, s_ready, s_last;
    logic [447:0] s_data;
    logic [15:0]  s_len;
    logic         core_en, core_valid_in, core_valid_out;
    logic [447:0] core_m_in;
    logic [15:0]  core_length;
    logic [31:0]  core_a, core_b, core_c, core_d;
    logic [511:0] core_m_out;
    logic         match_valid, match_ready;
    logic [447:0] match_msg;
    logic [15:0]  match_len;
    logic [31:0]  hash_count, match_count;

    int npass = 0, ntot = 0, nfail = 0;

    always #5 clk = ~clk;

    md5_search_ctrl #(.PIPE_DEPTH(PD), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_target(cfg_target),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len), .s_last(s_last),
        .core_en(core_en), .core_m_in(core_m_in), .core_length(core_length),
        .core_valid_in(core_valid_in),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .core_m_out(core_m_out), .core_valid_out(core_valid_out),
        .match_valid(match_valid), .match_ready(match_ready),
        .match_msg(match_msg), .match_len(match_len),
        .hash_count(hash_count), .match_count(match_count)
    );

    // Core model: enable-gated delay line, digest looked up from the message.
    function automatic logic [127:0] dig(input logic [447:0] m);
        if (m == ABC_MSG) return ABC_DIG;
        if (m[447:440] == 8'hAA) return TGT2;
        return {96'h0, m[31:0]};
    endfunction

    logic [464:0] pipe [PD];
    logic [447:0] tail_m;
    logic [15:0]  tail_len;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PD; i++) pipe[i] <= '0;
        end else if (core_en) begin
            pipe[0] <= {core_valid_in, core_m_in, core_length};
            for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign core_valid_out = pipe[PD-1][464];
    assign tail_m         = pipe[PD-1][463:16];
    assign tail_len       = pipe[PD-1][15:0];
    assign core_m_out     = {tail_m, tail_len[7:0], tail_len[15:8], 48'h0};
    assign {core_a, core_b, core_c, core_d} = dig(tail_m);

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [127:0] tgt);
        @(negedge clk);
        cfg_target = tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    bit           seen, ok;
    int           cyc, nmatch, acc, idx;
    logic [447:0] cap;

    initial begin
        reset = 1'b1; start = 1'b0; cfg_target = '0; match_ready = 1'b0;
        s_valid = 1'b0; s_data = '0; s_len = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",        512'(busy),          '0);
        chk("rst_done",        512'(done),          '0);
        chk("rst_s_ready",     512'(s_ready),       '0);
        chk("rst_match_valid", 512'(match_valid),   '0);
        chk("rst_match_msg",   512'(match_msg),     '0);
        chk("rst_match_len",   512'(match_len),     '0);
        chk("rst_hash_count",  512'(hash_count),    '0);
        chk("rst_match_count", 512'(match_count),   '0);
        s_valid = 1'b1; s_data = ABC_MSG;
        @(negedge clk);
        chk("idle_s_ready",    512'(s_ready),       '0);
        chk("idle_valid_in",   512'(core_valid_in), '0);
        s_valid = 1'b0;

        // Single "abc" candidate: 66-cycle latency to match_valid.
        do_start(ABC_DIG);
        s_valid = 1'b1; s_data = ABC_MSG; s_len = 16'd24; s_last = 1'b1;
        chk("abc_busy",    512'(busy),    512'(1));
        chk("abc_s_ready", 512'(s_ready), 512'(1));
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; cyc = 1;
        chk("abc_drain_s_ready", 512'(s_ready), '0);
        while (!match_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abc_latency",     512'(cyc),         512'(66));
        chk("abc_match_len",   512'(match_len),   512'(24));
        chk("abc_match_msg",   512'(match_msg),   512'(ABC_MSG));
        chk("abc_hash_count",  512'(hash_count),  512'(1));
        chk("abc_match_count", 512'(match_count), 512'(1));
        match_ready = 1'b1;
        wait_done(20, seen);
        chk("abc_done", 512'(seen), 512'(1));
        @(negedge clk);
        chk("abc_done_pulse", 512'(done), '0);
        chk("abc_idle_busy",  512'(busy), '0);

`ifndef MD5_CTRL_STOP_ON_MATCH_EN
        // 100 back-to-back candidates, index 57 matches.
        do_start(TGT2);
        match_ready = 1'b1; ok = 1'b1; nmatch = 0; cap = '0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_data  = {((i == 57) ? 8'hAA : 8'h11), 408'h0, 32'(i)};
            s_len   = 16'(i);
            s_last  = (i == 99);
            if (!s_ready) ok = 1'b0;
            if (match_valid) begin nmatch++; cap = match_msg; end
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (match_valid) begin nmatch++; cap = match_msg; end
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("b2b_ready_always", 512'(ok),          512'(1));
        chk("b2b_done",         512'(seen),        512'(1));
        chk("b2b_one_match",    512'(nmatch),      512'(1));
        chk("b2b_match_msg",    512'(cap),         512'({8'hAA, 408'h0, 32'd57}));
        chk("b2b_hash_count",   512'(hash_count),  512'(100));
        chk("b2b_match_count",  512'(match_count), 512'(1));

        // Backpressure: two consecutive hits with match_ready low.
        do_start(TGT2);
        match_ready = 1'b0;
        s_valid = 1'b1; s_data = {8'hAA, 408'h0, 32'd200};
        @(negedge clk);
        s_data = {8'hAA, 408'h0, 32'd201};
        @(negedge clk);
        s_valid = 1'b0; cyc = 0;
        while (!match_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_first_msg", 512'(match_msg), 512'({8'hAA, 408'h0, 32'd200}));
        s_valid = 1'b1; s_data = {8'h11, 408'h0, 32'd202}; s_last = 1'b1; ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (core_en || s_ready) ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_stalled",     512'(ok),          512'(1));
        chk("bp_first_held",  512'(match_msg),   512'({8'hAA, 408'h0, 32'd200}));
        match_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        chk("bp_second_valid", 512'(match_valid), 512'(1));
        chk("bp_second_msg",   512'(match_msg),   512'({8'hAA, 408'h0, 32'd201}));
        wait_done(200, seen);
        chk("bp_done",        512'(seen),        512'(1));
        chk("bp_match_count", 512'(match_count), 512'(2));
        chk("bp_hash_count",  512'(hash_count),  512'(3));
`else
        // Stop on first hit: 20 hits at the head of a 100-beat stream.
        do_start(TGT2);
        match_ready = 1'b1; idx = 0; acc = 0; nmatch = 0; seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (idx < 100) begin
                s_valid = 1'b1;
                s_data  = {((idx < 20) ? 8'hAA : 8'h11), 408'h0, 32'(idx)};
                s_last  = (idx == 99);
            end else begin
                s_valid = 1'b0;
            end
            if (match_valid) nmatch++;
            if (done) begin seen = 1'b1; break; end
            if (s_valid && s_ready) begin acc++; idx++; end
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("stop_done",        512'(seen),        512'(1));
        chk("stop_accepted",    512'(acc),         512'(66));
        chk("stop_presented",   512'(nmatch),      512'(1));
        chk("stop_match_count", 512'(match_count), 512'(20));
        chk("stop_hash_count",  512'(hash_count),  512'(66));
`endif

        // Reset while draining 30 in-flight candidates.
        do_start(TGT2);
        match_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1; s_data = {8'h22, 408'h0, 32'(i)}; s_last = (i == 29);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("rd_busy_drain", 512'(busy), 512'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rd_busy",        512'(busy),        '0);
        chk("rd_hash_count",  512'(hash_count),  '0);
        chk("rd_match_count", 512'(match_count), '0);
        chk("rd_match_msg",   512'(match_msg),   '0);
        wait_done(80, seen);
        chk("rd_no_done", 512'(seen), '0);
        do_start(ABC_DIG);
        s_valid = 1'b1; s_data = ABC_MSG; s_len = 16'd24; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(200, seen);
        chk("rd_job_done",        512'(seen),        512'(1));
        chk("rd_job_hash_count",  512'(hash_count),  512'(1));
        chk("rd_job_match_count", 512'(match_count), 512'(1));
        chk("rd_job_match_len",   512'(match_len),   512'(24));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/md5_search_ctrl.md
Name: md5_search_ctrl

Overview:
- Sequencer and scheduler for the 64-round MD5 pipeline core.
- Accepts a stream of pre-padded candidate messages (valid/ready) and issues one per cycle into the core.
- Drives the core's global enable for backpressure and compares every retiring digest against a latched target.
- Reports matches through a valid/ready result port; tracks in-flight work so it can drain the pipeline and report completion.

Parameters:
PIPE_DEPTH, 65, cycles from core valid_in sample to core valid_out (64 rounds + output register); sizes the in-flight counter.
CNT_W, 32, width of hash_count and match_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; also wired to the core's reset
start  in  1  1-cycle pulse; begins a job (ignored unless IDLE)
cfg_target  in  128  target digest {a,b,c,d}, in the core's byte-swapped output order; latched on start
busy  out  1  high in RUN or DRAIN
done  out  1  1-cycle pulse when the job completes
s_valid  in  1  candidate valid
s_ready  out  1  candidate accepted when s_valid && s_ready
s_data  in  448  padded message block (message bytes, 0x80, zeros), first byte in [447:440]
s_len  in  16  message length in bits, big-endian value
s_last  in  1  final candidate of the job
core_en  out  1  core global enable
core_m_in  out  448  to core m_in
core_length  out  16  to core length
core_valid_in  out  1  to core valid_in
core_a, core_b, core_c, core_d  in  32 each  core digest outputs
core_m_out  in  512  core m_out
core_valid_out  in  1  core valid_out
match_valid  out  1  match result held
match_ready  in  1  consumer accepts match
match_msg  out  448  core_m_out[511:64] of matching candidate
match_len  out  16  {core_m_out[55:48], core_m_out[63:56]}
hash_count  out  CNT_W  digests retired this job
match_count  out  CNT_W  matches found this job

Behaviour:
- Reset: state=IDLE; busy=0, done=0, s_ready=0, core_valid_in=0, match_valid=0, match_msg=0, match_len=0, hash_count=0, match_count=0, inflight=0, target=0.
- Reset mid-job: abandons the job; the core is flushed by the shared reset; no done pulse.
- core_en = !match_valid || match_ready (combinational). Stalls the whole core while a match is unconsumed.
- core_m_in, core_length: wired from s_data and s_len.
- core_valid_in = s_valid && s_ready.
- s_ready = (state==RUN) && core_en.
- Retire event: core_en && core_valid_out.
- Hit: retire && {core_a,core_b,core_c,core_d}==target.
- hash_count increments on every retire.
- On a hit: match_count increments; match_msg and match_len are registered; match_valid is set.
- match_valid clears on match_valid && match_ready, unless a new hit occurs in the same cycle. In that case the new match is loaded and match_valid stays 1.
- inflight (clog2(PIPE_DEPTH+1) bits): +1 on accept, -1 on retire; accept and retire in the same cycle leave it unchanged. It never exceeds PIPE_DEPTH.
- Latency: candidate accepted at cycle T with no stalls gives core_valid_out at T+PIPE_DEPTH and match_valid high at T+PIPE_DEPTH+1. Each stall cycle adds 1.
- FSM:
  - IDLE: on start, latch target, clear counters → RUN.
  - RUN: accept candidates; an accepted beat with s_last → DRAIN.
  - DRAIN: s_ready=0; when inflight==0 && !match_valid → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- The counters and the last match hold their values in IDLE until the next start.
- Any retire while in IDLE is ignored and not counted; this cannot occur after a normal drain.
- Counter wrap: both counters wrap modulo 2^CNT_W, with no saturation.

Optional Feature:
- Macro: MD5_CTRL_STOP_ON_MATCH_EN.
- When defined, the first hit in RUN forces → DRAIN: s_ready drops the following cycle and remaining stream beats are left unconsumed.
- In DRAIN, later hits still count in match_count but are not presented; match_msg and match_valid are not updated.
- When undefined, every hit is presented and the stream is consumed through s_last.

Test Plan:
- Reset then idle: all outputs 0; s_valid=1 held in IDLE → s_ready=0; no core_valid_in.
- Single "abc": start with target=128'h900150983cd24fb0d6963f7d28e17f72; s_data=448'h61626380_0…0, s_len=24, s_last=1, accepted at T → match_valid at T+66, match_len=24, match_msg=s_data, hash_count=1; match_ready=1 → done pulse, busy=0.
- 100 back-to-back candidates, one matching (index 57), match_ready tied 1 → s_ready continuously 1, exactly one match, hash_count=100, match_count=1, done after the last retire.
- Backpressure: two consecutive matching candidates, match_ready=0 for 10 cycles → core_en=0 and s_ready=0 throughout; second match appears the cycle after the first is accepted; neither is lost; match_count=2.
- Reset asserted in DRAIN with inflight=30 → next cycle IDLE, counters 0, no done; a new job then completes correctly.
- With MD5_CTRL_STOP_ON_MATCH_EN: 20 matching candidates → one match presented, stream stalls after the first hit, done after drain, match_count equals the number of hits that were in flight.
